// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the sensor target and the polling controller:
// FSM state encodings, ACK/NACK line levels and the sensor bus addresses.
package i2c_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ADDR     = 3'd1;
   localparam logic [2:0] ST_ADDR_ACK = 3'd2;
   localparam logic [2:0] ST_TX_BYTE  = 3'd3;
   localparam logic [2:0] ST_TX_ACK   = 3'd4;
   localparam logic [2:0] ST_RX_BYTE  = 3'd5;
   localparam logic [2:0] ST_RX_ACK   = 3'd6;
   localparam logic [2:0] ST_IGNORE   = 3'd7;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam logic [6:0] I2C_ADDR_TEMP = 7'h48;
   localparam logic [6:0] I2C_ADDR_LUX  = 7'h23;

   // Address byte is {addr[6:0], rw}; only the upper seven bits identify the target.
   function automatic logic addr_hit(input logic [7:0] i_byte, input logic [6:0] i_addr);
      return (i_byte[7:1] == i_addr);
   endfunction

endpackage

// File: rtl/i2c_line_monitor.sv
// Two-flop synchronizers for SDA/SCL plus SCL edge and START/STOP detection,
// all derived from the synchronized samples and their one-cycle-old copies.
module i2c_line_monitor (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sda,
   input  logic i_scl,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start_det,
   output logic o_stop_det
);

   logic r_sda_m, r_sda_s, r_sda_p;
   logic r_scl_m, r_scl_s, r_scl_p;

   // Reset to the idle-bus level so leaving reset never looks like an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sda_m <= 1'b1;
         r_sda_s <= 1'b1;
         r_sda_p <= 1'b1;
         r_scl_m <= 1'b1;
         r_scl_s <= 1'b1;
         r_scl_p <= 1'b1;
      end else begin
         r_sda_m <= i_sda;
         r_sda_s <= r_sda_m;
         r_sda_p <= r_sda_s;
         r_scl_m <= i_scl;
         r_scl_s <= r_scl_m;
         r_scl_p <= r_scl_s;
      end
   end

   assign o_sda       = r_sda_s;
   assign o_scl_rise  = r_scl_s & ~r_scl_p;
   assign o_scl_fall  = ~r_scl_s & r_scl_p;
   assign o_start_det = r_sda_p & ~r_sda_s & r_scl_s & r_scl_p;
   assign o_stop_det  = ~r_sda_p & r_sda_s & r_scl_s & r_scl_p;

endmodule

// File: rtl/i2c_sensor_target.sv
// I2C target emulating a 16-bit sensor: two-byte big-endian reads of tx_data.
// Define I2C_TARGET_WRITE_EN to accept write bytes on wr_data/wr_valid.
module i2c_sensor_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = I2C_ADDR_TEMP
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire         sda,
   inout  wire         scl,
   input  logic [15:0] tx_data,
   output logic        busy,
   output logic        rd_done,
   output logic [7:0]  wr_data,
   output logic        wr_valid
);

`ifdef I2C_TARGET_WRITE_EN
   localparam logic WR_EN = 1'b1;
`else
   localparam logic WR_EN = 1'b0;
`endif

   logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

   logic [2:0]  r_state;
   logic [3:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic [15:0] r_tx_word;
   logic        r_byte_sel;
   logic        r_rw;
   logic        r_ack_on;
   logic        r_sda_low;
   logic        r_busy;
   logic        r_rd_done;
`ifdef I2C_TARGET_WRITE_EN
   logic [7:0]  r_wr_data;
   logic        r_wr_valid;
`endif

   i2c_line_monitor u_mon (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_sda       (sda),
      .i_scl       (scl),
      .o_sda       (w_sda),
      .o_scl_rise  (w_scl_rise),
      .o_scl_fall  (w_scl_fall),
      .o_start_det (w_start),
      .o_stop_det  (w_stop)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 4'd0;
         r_byte_sel <= 1'b0;
         r_rw       <= 1'b0;
         r_ack_on   <= 1'b0;
         r_sda_low  <= 1'b0;
         r_busy     <= 1'b0;
         r_rd_done  <= 1'b0;
`ifdef I2C_TARGET_WRITE_EN
         r_wr_data  <= 8'h00;
         r_wr_valid <= 1'b0;
`endif
      end else begin
         r_rd_done <= 1'b0;
`ifdef I2C_TARGET_WRITE_EN
         r_wr_valid <= 1'b0;
`endif
         if (w_stop) begin
            r_state   <= ST_IDLE;
            r_sda_low <= 1'b0;
            r_busy    <= 1'b0;
         end else if (w_start) begin
            r_state   <= ST_ADDR;
            r_bit_cnt <= 4'd0;
            r_sda_low <= 1'b0;
            r_ack_on  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: ;
               ST_ADDR: begin
                  if (w_scl_rise) begin
                     r_shift   <= {r_shift[6:0], w_sda};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        // Without write support a write-direction match is left unacknowledged.
                        if (addr_hit({r_shift[6:0], w_sda}, TARGET_ADDR) && (w_sda || WR_EN)) begin
                           r_state  <= ST_ADDR_ACK;
                           r_rw     <= w_sda;
                           r_busy   <= 1'b1;
                           r_ack_on <= 1'b0;
                        end else begin
                           r_state <= ST_IGNORE;
                           r_busy  <= 1'b0;
                        end
                     end
                  end
               end
               ST_ADDR_ACK, ST_RX_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_ack_on) begin
                        r_sda_low <= ~ACK;
                        r_ack_on  <= 1'b1;
                     end else begin
                        r_ack_on  <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        if (r_state == ST_ADDR_ACK && r_rw) begin
                           // Capture the whole word once and put its MSB on the bus right away.
                           r_state    <= ST_TX_BYTE;
                           r_tx_word  <= tx_data;
                           r_byte_sel <= 1'b1;
                           r_sda_low  <= ~tx_data[15];
                           r_shift    <= {tx_data[14:8], 1'b0};
                        end else begin
                           r_state   <= WR_EN ? ST_RX_BYTE : ST_IGNORE;
                           r_sda_low <= 1'b0;
                        end
                     end
                  end
               end
               ST_TX_BYTE: begin
                  if (w_scl_rise) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd8) begin
                        r_sda_low <= 1'b0;
                        r_state   <= ST_TX_ACK;
                     end else begin
                        r_sda_low <= ~r_shift[7];
                        r_shift   <= {r_shift[6:0], 1'b0};
                     end
                  end
               end
               ST_TX_ACK: begin
                  if (w_scl_rise) begin
                     if (w_sda == ACK) begin
                        r_shift    <= r_byte_sel ? r_tx_word[7:0] : r_tx_word[15:8];
                        r_byte_sel <= ~r_byte_sel;
                        r_bit_cnt  <= 4'd0;
                        r_state    <= ST_TX_BYTE;
                     end else begin
                        r_rd_done <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IGNORE;
                     end
                  end
               end
`ifdef I2C_TARGET_WRITE_EN
               ST_RX_BYTE: begin
                  if (w_scl_rise) begin
                     r_shift   <= {r_shift[6:0], w_sda};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        r_wr_data  <= {r_shift[6:0], w_sda};
                        r_wr_valid <= 1'b1;
                        r_ack_on   <= 1'b0;
                        r_state    <= ST_RX_ACK;
                     end
                  end
               end
`endif
               ST_IGNORE: r_sda_low <= 1'b0;
               default: begin
                  r_state   <= ST_IDLE;
                  r_sda_low <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda     = r_sda_low ? 1'b0 : 1'bz;
   assign scl     = 1'bz;
   assign busy    = r_busy;
   assign rd_done = r_rd_done;
`ifdef I2C_TARGET_WRITE_EN
   assign wr_data  = r_wr_data;
   assign wr_valid = r_wr_valid;
`else
   assign wr_data  = 8'h00;
   assign wr_valid = 1'b0;
`endif

endmodule
